// File: rtl/npc_pkg.sv
// npc_pkg: shared definitions for the NPC multi-cycle sequencer.
//  - seq_state_e : 3-bit sequencer state encoding
//  - NPC_TIMEOUT_CYC : default PMEM wait timeout in cycles (0 disables)
//  - PMEM op constants for the request fetch/wen fields
package npc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_REQ,
        ST_FETCH_WAIT,
        ST_EXEC,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_WB,
        ST_HALT,
        ST_ERROR
    } seq_state_e;

    localparam int unsigned NPC_TIMEOUT_CYC = 255;

    localparam logic PMEM_OP_FETCH = 1'b1;
    localparam logic PMEM_OP_DATA  = 1'b0;
    localparam logic PMEM_WEN_RD   = 1'b0;
    localparam logic PMEM_WEN_WR   = 1'b1;

endpackage

// File: rtl/npc_seq_timeout.sv
// npc_seq_timeout: wait-cycle counter for the sequencer's PMEM wait states.
//  clk, rst : clock, asynchronous active-high reset
//  clear    : zero the counter (held while a request is being presented)
//  inc      : count one wait cycle
//  expired  : this wait cycle is the LIMIT-th one without a response
// LIMIT = 0 disables expiry. TO_W must be able to hold LIMIT.
module npc_seq_timeout #(
    parameter int unsigned TO_W  = 8,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [TO_W:0] LIM = (TO_W + 1)'(LIMIT);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cnt <= '0;
        else if (clear) cnt <= '0;
        else if (inc)   cnt <= cnt + 1'b1;
    end

    // cnt holds completed wait cycles; this cycle is number cnt+1.
    assign expired = (LIMIT != 0) && inc && (({1'b0, cnt} + 1'b1) == LIM);

endmodule

// File: rtl/npc_multicycle_sequencer.sv
// npc_multicycle_sequencer: steps each instruction through fetch, execute,
// optional memory access and writeback over one shared PMEM request port,
// gating register-file write and PC update so each instruction retires once.
//  clk, rst                 : clock, asynchronous active-high reset
//  dec_load/store/wreg/halt : decoded instruction attributes
//  mem_req_valid/ready      : PMEM request handshake
//  mem_req_fetch/wen        : request type (fetch at PC / data, store)
//  mem_rsp_valid            : PMEM response pulse
//  ir_we, ld_we             : instruction / load-data register latch pulses
//  rf_we, pc_we, retire     : writeback strobes
//  halted, bus_err          : sticky terminal status
// Optional: NPC_PERF_CNT_EN adds perf_cycles / perf_instret counters.
module npc_multicycle_sequencer
    import npc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = NPC_TIMEOUT_CYC,
    parameter int unsigned TO_W        = 8
`ifdef NPC_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W      = 64
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic dec_load,
    input  logic dec_store,
    input  logic dec_wreg,
    input  logic dec_halt,
    output logic mem_req_valid,
    input  logic mem_req_ready,
    output logic mem_req_fetch,
    output logic mem_req_wen,
    input  logic mem_rsp_valid,
    output logic ir_we,
    output logic ld_we,
    output logic rf_we,
    output logic pc_we,
    output logic retire,
    output logic halted,
    output logic bus_err
`ifdef NPC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_instret
`endif
);

    seq_state_e state, state_nxt;
    logic       req_st, wait_st, to_exp, live;

    assign req_st  = (state == ST_FETCH_REQ) || (state == ST_MEM_REQ);
    assign wait_st = (state == ST_FETCH_WAIT) || (state == ST_MEM_WAIT);

    // Clearing for the whole request phase is equivalent to clearing on
    // entry to the wait state, since the two phases always alternate.
    npc_seq_timeout #(
        .TO_W  (TO_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (req_st),
        .inc     (wait_st),
        .expired (to_exp)
    );

    // A response outside a wait state is spurious and wins over any other
    // transition; in a wait state a response wins over expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH_REQ:  if (mem_rsp_valid)      state_nxt = ST_ERROR;
                           else if (mem_req_ready) state_nxt = ST_FETCH_WAIT;
            ST_FETCH_WAIT: if (mem_rsp_valid)      state_nxt = ST_EXEC;
                           else if (to_exp)        state_nxt = ST_ERROR;
            ST_EXEC:       if (mem_rsp_valid)      state_nxt = ST_ERROR;
                           else if (dec_halt)      state_nxt = ST_HALT;
                           else if (dec_load || dec_store)
                                                   state_nxt = ST_MEM_REQ;
                           else                    state_nxt = ST_WB;
            ST_MEM_REQ:    if (mem_rsp_valid)      state_nxt = ST_ERROR;
                           else if (mem_req_ready) state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT:   if (mem_rsp_valid)      state_nxt = ST_WB;
                           else if (to_exp)        state_nxt = ST_ERROR;
            ST_WB:         if (mem_rsp_valid)      state_nxt = ST_ERROR;
                           else                    state_nxt = ST_FETCH_REQ;
            default:                               state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FETCH_REQ;
        else     state <= state_nxt;
    end

    // The state already sits in FETCH_REQ during reset; masking with rst keeps
    // every output at 0 until release, so the first request appears right after.
    assign live = !rst;

    assign mem_req_valid = live && req_st;
    assign mem_req_fetch = live && ((state == ST_FETCH_REQ) ? PMEM_OP_FETCH : PMEM_OP_DATA);
    assign mem_req_wen   = live && ((state == ST_MEM_REQ && dec_store) ? PMEM_WEN_WR : PMEM_WEN_RD);
    assign ir_we         = live && (state == ST_FETCH_WAIT) && mem_rsp_valid;
    assign ld_we         = live && (state == ST_MEM_WAIT) && mem_rsp_valid && dec_load;
    assign rf_we         = live && (state == ST_WB) && dec_wreg;
    assign pc_we         = live && (state == ST_WB);
    assign retire        = live && (state == ST_WB);
    assign halted        = live && (state == ST_HALT);
    assign bus_err       = live && (state == ST_ERROR);

`ifdef NPC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles  <= '0;
            perf_instret <= '0;
        end else begin
            if (state != ST_HALT && state != ST_ERROR) perf_cycles <= perf_cycles + 1'b1;
            if (state == ST_WB) perf_instret <= perf_instret + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_npc_multicycle_sequencer.sv
// tb_npc_multicycle_sequencer: self-checking bench. Each instruction is
// described by its kind and the ready/response delays the bench chooses; the
// expected strobe pattern of every cycle follows from that description.
// Inputs change on the falling edge, outputs are sampled 2 time units later.
module tb_npc_multicycle_sequencer;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;
    logic dec_load, dec_store, dec_wreg, dec_halt;
    logic mem_req_valid, mem_req_ready, mem_req_fetch, mem_req_wen, mem_rsp_valid;
    logic ir_we, ld_we, rf_we, pc_we, retire, halted, bus_err;
`ifdef NPC_PERF_CNT_EN
    logic [63:0] perf_cycles, perf_instret;
`endif

    npc_multicycle_sequencer #(
        .TIMEOUT_CYC (TO),
        .TO_W        (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dec_load      (dec_load),
        .dec_store     (dec_store),
        .dec_wreg      (dec_wreg),
        .dec_halt      (dec_halt),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_fetch (mem_req_fetch),
        .mem_req_wen   (mem_req_wen),
        .mem_rsp_valid (mem_rsp_valid),
        .ir_we         (ir_we),
        .ld_we         (ld_we),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .retire        (retire),
        .halted        (halted),
        .bus_err       (bus_err)
`ifdef NPC_PERF_CNT_EN
        ,
        .perf_cycles   (perf_cycles),
        .perf_instret  (perf_instret)
`endif
    );

    always #5 clk = ~clk;

    // {req_valid, fetch, wen, ir_we, ld_we, rf_we, pc_we, retire, halted, bus_err}
    wire [9:0] obs = {mem_req_valid, mem_req_fetch, mem_req_wen, ir_we, ld_we,
                      rf_we, pc_we, retire, halted, bus_err};

    localparam logic [9:0] E_NONE = 10'b00_0000_0000;
    localparam logic [9:0] E_FREQ = 10'b11_0000_0000;
    localparam logic [9:0] E_IR   = 10'b00_0100_0000;
    localparam logic [9:0] E_HALT = 10'b00_0000_0010;
    localparam logic [9:0] E_ERR  = 10'b00_0000_0001;

    int n_chk  = 0;
    int n_fail = 0;
    int n_ret  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive, sample, advance to the next falling edge.
    task automatic cyc(input string tag, input logic rdy, input logic rsp, input logic [9:0] exp);
        mem_req_ready = rdy;
        mem_rsp_valid = rsp;
        #2;
        check(tag, 32'(obs), 32'(exp));
        @(negedge clk);
    endtask

    task automatic fetch(input int fd, input int fr);
        for (int i = 0; i <= fd; i++) cyc("fetch_req", i == fd, 1'b0, E_FREQ);
        for (int j = 1; j <= fr; j++) cyc("fetch_wait", rbit(), j == fr, (j == fr) ? E_IR : E_NONE);
    endtask

    task automatic mem_req(input int md, input logic st);
        for (int i = 0; i <= md; i++) cyc("mem_req", i == md, 1'b0, {2'b10, st, 7'b0});
    endtask

    task automatic mem_wait(input int mr, input logic ld);
        for (int j = 1; j <= mr; j++)
            cyc("mem_wait", rbit(), j == mr, (j == mr) ? {4'b0, ld, 5'b0} : E_NONE);
    endtask

    task automatic wb(input logic wr);
        cyc("wb", rbit(), 1'b0, {5'b0, wr, 4'b1100});
        n_ret++;
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 ebreak
    task automatic instr(input int kind, input logic wr, input int fd, input int fr,
                         input int md, input int mr);
        dec_load  = (kind == 1);
        dec_store = (kind == 2);
        dec_halt  = (kind == 3);
        dec_wreg  = wr;
        fetch(fd, fr);
        cyc("exec", rbit(), 1'b0, E_NONE);
        if (kind == 3) begin
            for (int k = 0; k < 6; k++) cyc("halt", rbit(), rbit(), E_HALT);
        end else begin
            if (kind != 0) begin
                mem_req(md, kind == 2);
                mem_wait(mr, kind == 1);
            end
            wb(wr);
        end
    endtask

    // Assert reset mid-cycle: outputs must clear without waiting for a clock.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", 32'(obs), 32'(E_NONE));
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        n_ret = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {dec_load, dec_store, dec_wreg, dec_halt, mem_req_ready, mem_rsp_valid} = '0;
        @(negedge clk);
        #2;
        check("reset_state", 32'(obs), 32'(E_NONE));
        @(negedge clk);
        rst = 1'b0;

        // Minimum-latency ALU op, load with a stalled request, store without rd.
        instr(0, 1'b1, 0, 1, 0, 0);
        instr(1, 1'b1, 0, 1, 3, 1);
        instr(2, 1'b0, 0, 1, 0, 1);
        // Response in the last permitted wait cycle still progresses.
        instr(0, 1'b1, 1, TO, 0, 0);
        instr(1, 1'b0, 2, 2, 0, TO);

        // Fetch timeout: TO silent wait cycles, then terminal error.
        fetch(0, 0);
        for (int j = 0; j < TO; j++) cyc("fetch_to_wait", rbit(), 1'b0, E_NONE);
        for (int k = 0; k < 4; k++) cyc("fetch_to_err", rbit(), rbit(), E_ERR);
        do_reset();

        // Memory-wait timeout.
        dec_load = 1'b1; dec_store = 1'b0; dec_halt = 1'b0; dec_wreg = 1'b1;
        fetch(0, 1);
        cyc("exec", 1'b0, 1'b0, E_NONE);
        mem_req(0, 1'b0);
        for (int j = 0; j < TO; j++) cyc("mem_to_wait", rbit(), 1'b0, E_NONE);
        cyc("mem_to_err", 1'b0, 1'b0, E_ERR);
        do_reset();

        // Reset while waiting on a load response, then a clean restart.
        fetch(1, 2);
        cyc("exec", 1'b0, 1'b0, E_NONE);
        mem_req(1, 1'b0);
        cyc("mem_wait_pre_rst", 1'b0, 1'b0, E_NONE);
        do_reset();
        cyc("post_rst_req", 1'b0, 1'b0, E_FREQ);
        cyc("post_rst_req", 1'b1, 1'b0, E_FREQ);
        cyc("post_rst_wait", 1'b0, 1'b1, E_IR);
        dec_load = 1'b0;
        cyc("exec", 1'b0, 1'b0, E_NONE);
        wb(1'b1);

        // Spurious response in EXEC.
        dec_load = 1'b0;
        fetch(0, 1);
        cyc("spurious_exec", 1'b0, 1'b1, E_NONE);
        cyc("spurious_err", 1'b0, 1'b0, E_ERR);
        do_reset();

        // ebreak halts for good.
        instr(0, 1'b1, 0, 1, 0, 0);
        instr(3, 1'b1, 0, 1, 0, 0);
        do_reset();

        // Randomized instruction stream.
        for (int n = 0; n < 200; n++) begin
            int kind;
            kind = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
            instr(kind, rbit(), $urandom_range(0, 3), $urandom_range(1, TO),
                  $urandom_range(0, 3), $urandom_range(1, TO));
            if (kind == 3) do_reset();
        end

`ifdef NPC_PERF_CNT_EN
        #2;
        check("perf_instret", 32'(perf_instret), 32'(n_ret));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
